// File: rtl/double_fig_merge_if.sv
// double_fig_merge_if: digit-entry bus between the keypad/button logic and the
// two-digit merger.
//   master : keypad side, drives i_digit/i_digit_vld/i_cancel and observes results
//   slave  : merger side, consumes digits and drives the merged value, pulses and
//            the display echo (o_left/o_right)
interface double_fig_merge_if;
  logic [3:0] i_digit;
  logic       i_digit_vld;
  logic       i_cancel;
  logic [5:0] o_double_fig;
  logic       o_fig_vld;
  logic       o_err;
  logic       o_busy;
  logic [3:0] o_left;
  logic [3:0] o_right;

  modport master (
    output i_digit, i_digit_vld, i_cancel,
    input  o_double_fig, o_fig_vld, o_err, o_busy, o_left, o_right
  );

  modport slave (
    input  i_digit, i_digit_vld, i_cancel,
    output o_double_fig, o_fig_vld, o_err, o_busy, o_left, o_right
  );
endinterface

// File: rtl/double_fig_merge.sv
// double_fig_merge: assembles two serially entered decimal digits (tens, then
// ones) into one 0..MAX_VAL binary value for the clock time-set path.
//   clk, rst_n        : clock, asynchronous active-low reset
//   bus.i_digit       : entered digit, sampled when bus.i_digit_vld=1
//   bus.i_cancel      : abort current entry (beats digit strobe and timeout)
//   bus.o_double_fig  : last accepted merged value, held between entries
//   bus.o_fig_vld     : one-cycle pulse, o_double_fig updated
//   bus.o_err         : one-cycle pulse, entry rejected or timed out
//   bus.o_busy        : waiting for the ones digit
//   bus.o_left/right  : partial digits echoed to the display path
module double_fig_merge #(
  parameter int MAX_VAL     = 59,
  parameter int TIMEOUT_CYC = 100000000
) (
  input  logic               clk,
  input  logic               rst_n,
  double_fig_merge_if.slave  bus
);
  localparam int CW = $clog2(TIMEOUT_CYC);

  typedef enum logic {IDLE = 1'b0, WAIT_ONES = 1'b1} state_t;

  state_t        state;
  logic [3:0]    tens;
  logic [CW-1:0] cnt;

  logic       d_dec;     // digit is a legal decimal digit
  logic       tens_ok;   // digit usable as tens without exceeding MAX_VAL
  logic [6:0] val;       // tens*10 + ones; tens<=6 keeps this below 128
  logic       tmo;

  assign d_dec   = (bus.i_digit <= 4'd9);
  assign tens_ok = d_dec && (({4'b0, bus.i_digit} * 8'd10) <= 8'(MAX_VAL));
  assign val     = ({3'b0, tens} * 7'd10) + {3'b0, bus.i_digit};
  assign tmo     = (cnt == CW'(TIMEOUT_CYC - 1));

  assign bus.o_busy = (state == WAIT_ONES);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state            <= IDLE;
      tens             <= '0;
      cnt              <= '0;
      bus.o_double_fig <= '0;
      bus.o_fig_vld    <= 1'b0;
      bus.o_err        <= 1'b0;
      bus.o_left       <= '0;
      bus.o_right      <= '0;
    end else begin
      bus.o_fig_vld <= 1'b0;
      bus.o_err     <= 1'b0;
      if (bus.i_cancel) begin
        state       <= IDLE;
        cnt         <= '0;
        bus.o_left  <= '0;
        bus.o_right <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.i_digit_vld) begin
              if (tens_ok) begin
                tens        <= bus.i_digit;
                bus.o_left  <= bus.i_digit;
                bus.o_right <= '0;
                cnt         <= '0;
                state       <= WAIT_ONES;
              end else begin
                bus.o_err <= 1'b1;
              end
            end
          end
          WAIT_ONES: begin
            if (bus.i_digit_vld && !d_dec) begin
              // Non-decimal ones digit: flag it but keep the entry open and the
              // timeout running. If it lands on the last allowed cycle the entry
              // still expires; the single o_err pulse covers both.
              bus.o_err <= 1'b1;
              if (tmo) begin
                state       <= IDLE;
                cnt         <= '0;
                bus.o_left  <= '0;
                bus.o_right <= '0;
              end else begin
                cnt <= cnt + CW'(1);
              end
            end else if (bus.i_digit_vld && (val > 7'(MAX_VAL))) begin
              bus.o_err   <= 1'b1;
              state       <= IDLE;
              cnt         <= '0;
              bus.o_left  <= '0;
              bus.o_right <= '0;
            end else if (bus.i_digit_vld) begin
              bus.o_double_fig <= val[5:0];
              bus.o_right      <= bus.i_digit;
              bus.o_fig_vld    <= 1'b1;
              state            <= IDLE;
              cnt              <= '0;
            end else if (tmo) begin
              bus.o_err   <= 1'b1;
              state       <= IDLE;
              cnt         <= '0;
              bus.o_left  <= '0;
              bus.o_right <= '0;
            end else begin
              cnt <= cnt + CW'(1);
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end
endmodule
